// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the trace command sequencer.
// Holds the host command codes, the response codes, the valid trace-width
// encodings, the sequencer state enum and a helper that validates a raw
// width argument byte.
package cmd_pkg;

  // Host command bytes accepted in the idle state
  localparam logic [7:0] CmdWidth1   = 8'h31;  // '1'
  localparam logic [7:0] CmdWidth2   = 8'h32;  // '2'
  localparam logic [7:0] CmdWidth4   = 8'h34;  // '4'
  localparam logic [7:0] CmdEnable   = 8'h45;  // 'E'
  localparam logic [7:0] CmdDisable  = 8'h44;  // 'D'
  localparam logic [7:0] CmdWidthArg = 8'h57;  // 'W', followed by a raw width byte
  localparam logic [7:0] CmdStatus   = 8'h53;  // 'S'

  // Single-byte responses
  localparam logic [7:0] RespOk  = 8'h4B;  // 'K'
  localparam logic [7:0] RespNak = 8'h4E;  // 'N'

  // Trace port width encodings
  localparam logic [2:0] Width1 = 3'd1;
  localparam logic [2:0] Width2 = 3'd2;
  localparam logic [2:0] Width4 = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StArg,
    StResp,
    StStat0,
    StStat1,
    StStat2
  } state_e;

  // A raw argument byte is a legal width only if it is exactly 1, 2 or 4.
  function automatic logic arg_width_ok(input logic [7:0] arg);
    return (arg == 8'h01) || (arg == 8'h02) || (arg == 8'h04);
  endfunction

endpackage

// File: rtl/cmd_arg_timer.sv
// cmd_arg_timer: 16-bit cycle counter bounding the wait for an argument byte.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clear   - restart the count from zero
//   enable  - count this cycle
//   expired - high during the TIMEOUT-th enabled cycle after a clear
module cmd_arg_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The first enabled cycle sees a count of zero, so the last permitted
  // cycle sees TIMEOUT-1.
  localparam logic [15:0] Limit = 16'(TIMEOUT - 1);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= 16'd0;
    end else if (enable && !expired) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired = (count_q == Limit);

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: byte-oriented host command interpreter for the trace block.
// Accepts single-byte commands over a valid/ready rx channel, updates the
// trace configuration and answers over a valid/ready tx channel.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rxValid/rxByte      - host command byte in; rxReady accepts it
//   txValid/txByte      - response byte out (registered); txReady accepts it
//   ovfCount, syncLost  - capture-path status sampled by the 'S' command
//   traceWidth, traceEn - configuration outputs
module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  output logic        rxReady,
  output logic        txValid,
  output logic [7:0]  txByte,
  input  logic        txReady,
  input  logic [15:0] ovfCount,
  input  logic        syncLost,
  output logic [2:0]  traceWidth,
  output logic        traceEn
);

  state_e      state_q, state_d;
  logic [2:0]  width_q, width_d;
  logic        en_q, en_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] snap_ovf_q, snap_ovf_d;

  logic rx_fire, tx_fire;
  logic timer_clear, timer_en, timer_expired;

  assign rx_fire     = rxValid && rxReady;
  assign tx_fire     = tx_valid_q && txReady;
  assign timer_clear = (state_q == StIdle) && rx_fire && (rxByte == CmdWidthArg);
  assign timer_en    = (state_q == StArg);

  cmd_arg_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_arg_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      width_q    <= Width4;
      en_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      snap_ovf_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      en_q       <= en_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      snap_ovf_q <= snap_ovf_d;
    end
  end

  // Next state; tx byte/valid are computed here so they are registered and
  // change only on the edge that enters or leaves a response state.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    en_d       = en_q;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    snap_ovf_d = snap_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_byte_d  = RespOk;
          case (rxByte)
            CmdWidth1:  width_d = Width1;
            CmdWidth2:  width_d = Width2;
            CmdWidth4:  width_d = Width4;
            CmdEnable:  en_d = 1'b1;
            CmdDisable: en_d = 1'b0;
            CmdWidthArg: begin
              state_d    = StArg;
              tx_valid_d = 1'b0;
            end
            CmdStatus: begin
              // Status byte goes straight out; the counter is held for
              // the two following bytes.
              state_d    = StStat0;
              tx_byte_d  = {3'b000, syncLost, en_q, width_q};
              snap_ovf_d = ovfCount;
            end
            default:    tx_byte_d = RespNak;
          endcase
        end
      end
      StArg: begin
        // An argument arriving in the last permitted cycle wins over expiry.
        if (rx_fire) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          if (arg_width_ok(rxByte)) begin
            width_d   = rxByte[2:0];
            tx_byte_d = RespOk;
          end else begin
            tx_byte_d = RespNak;
          end
        end else if (timer_expired) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_byte_d  = RespNak;
        end
      end
      StResp: begin
        if (tx_fire) begin
          state_d    = StIdle;
          tx_valid_d = 1'b0;
        end
      end
      StStat0: begin
        if (tx_fire) begin
          state_d   = StStat1;
          tx_byte_d = snap_ovf_q[15:8];
        end
      end
      StStat1: begin
        if (tx_fire) begin
          state_d   = StStat2;
          tx_byte_d = snap_ovf_q[7:0];
        end
      end
      StStat2: begin
        if (tx_fire) begin
          state_d    = StIdle;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    rxReady    = (state_q == StIdle) || (state_q == StArg);
    txValid    = tx_valid_q;
    txByte     = tx_byte_q;
    traceWidth = width_q;
    traceEn    = en_q;
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of expected responses and configuration.
module tb_cmd_sequencer;

  localparam int unsigned TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        rxReady;
  logic        txValid;
  logic [7:0]  txByte;
  logic        txReady;
  logic [15:0] ovfCount;
  logic        syncLost;
  logic [2:0]  traceWidth;
  logic        traceEn;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_mode  = 0;  // 0 manual, 1 toggle, 2 random

  always #5 clk = ~clk;

  cmd_sequencer #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxValid   (rxValid),
    .rxByte    (rxByte),
    .rxReady   (rxReady),
    .txValid   (txValid),
    .txByte    (txByte),
    .txReady   (txReady),
    .ovfCount  (ovfCount),
    .syncLost  (syncLost),
    .traceWidth(traceWidth),
    .traceEn   (traceEn)
  );

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got_v, exp_v, $time);
    end
  endtask

  // Behavioural model: queue of response bytes still owed to the host,
  // current configuration, and whether an argument byte is awaited.
  logic [7:0] mq[$];
  logic [7:0] got[$];
  int         m_width = 4;
  bit         m_en = 0, m_arg = 0, m_live = 0, m_after_rst = 0;
  int         m_argcnt = 0;
  bit         prev_hold = 0;
  logic [7:0] prev_byte;

  always @(negedge clk) begin
    if (m_live) begin
      check("rxReady", rxReady, mq.size() == 0);
      check("txValid", txValid, mq.size() != 0);
      check("traceWidth", traceWidth, m_width);
      check("traceEn", traceEn, m_en);
      if (mq.size() != 0) check("txByte", txByte, mq[0]);
      if (m_after_rst) check("txByte_reset", txByte, 8'h00);
      if (prev_hold) check("txByte_stable", txByte, prev_byte);
    end
    if (txValid === 1'b1 && txReady === 1'b1 && rst === 1'b0) got.push_back(txByte);
    prev_hold   = (txValid === 1'b1) && (txReady === 1'b0) && (rst === 1'b0);
    prev_byte   = txByte;
    m_after_rst = 0;
    if (rst) begin
      mq.delete();
      m_width = 4; m_en = 0; m_arg = 0; m_argcnt = 0;
      m_live = 1; m_after_rst = 1;
    end else if (m_live) begin
      if (mq.size() != 0) begin
        if (txReady) void'(mq.pop_front());
      end else if (m_arg) begin
        if (rxValid) begin
          m_arg = 0;
          if (rxByte == 8'h01 || rxByte == 8'h02 || rxByte == 8'h04) begin
            m_width = int'(rxByte);
            mq.push_back(8'h4B);
          end else begin
            mq.push_back(8'h4E);
          end
        end else begin
          m_argcnt++;
          if (m_argcnt == TIMEOUT) begin
            m_arg = 0;
            mq.push_back(8'h4E);
          end
        end
      end else if (rxValid) begin
        case (rxByte)
          8'h31: begin m_width = 1; mq.push_back(8'h4B); end
          8'h32: begin m_width = 2; mq.push_back(8'h4B); end
          8'h34: begin m_width = 4; mq.push_back(8'h4B); end
          8'h45: begin m_en = 1; mq.push_back(8'h4B); end
          8'h44: begin m_en = 0; mq.push_back(8'h4B); end
          8'h57: begin m_arg = 1; m_argcnt = 0; end
          8'h53: begin
            mq.push_back({3'b000, syncLost, m_en, 3'(m_width)});
            mq.push_back(ovfCount[15:8]);
            mq.push_back(ovfCount[7:0]);
          end
          default: mq.push_back(8'h4E);
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (tx_mode == 1) txReady = ~txReady;
    else if (tx_mode == 2) txReady = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done    = 0;
    rxValid = 1'b1;
    rxByte  = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rxReady) done = 1;
      step();
    end
    rxValid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rxReady && !txValid) done = 1;
      else step();
    end
    if (!done) check("idle_timeout", 0, 1);
    step();
  endtask

  logic [7:0] pick[10];

  initial begin
    pick = '{8'h31, 8'h32, 8'h34, 8'h45, 8'h44, 8'h57, 8'h53, 8'h58, 8'h02, 8'h03};
    rst = 1'b1; rxValid = 1'b0; rxByte = 8'h00; txReady = 1'b0;
    ovfCount = 16'h0000; syncLost = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_txValid", txValid, 0);
    check("rst_txByte", txByte, 8'h00);
    check("rst_width", traceWidth, 4);
    check("rst_en", traceEn, 0);
    check("rst_rxReady", rxReady, 1);
    step();

    // '2' with txReady=1: width 2 one cycle later, single 'K'
    txReady = 1'b1; got.delete();
    send(8'h32);
    @(negedge clk);
    check("w2_width", traceWidth, 2);
    check("w2_txValid", txValid, 1);
    check("w2_txByte", txByte, 8'h4B);
    @(negedge clk);
    check("w2_idle_rxReady", rxReady, 1);
    check("w2_idle_txValid", txValid, 0);
    step();
    check("w2_count", got.size(), 1);

    // 'W' 0x03: width unchanged, 'N'
    send(8'h34); wait_idle(); got.delete();
    send(8'h57); send(8'h03); wait_idle();
    check("warg_count", got.size(), 1);
    if (got.size() > 0) check("warg_byte", got[0], 8'h4E);
    check("warg_width", traceWidth, 4);

    // 'E' then 'S' under toggling txReady
    got.delete();
    send(8'h45); wait_idle();
    ovfCount = 16'h1234; syncLost = 1'b1; tx_mode = 1;
    send(8'h53);
    ovfCount = 16'hBEEF; syncLost = 1'b0;
    wait_idle();
    tx_mode = 0; txReady = 1'b1;
    check("stat_count", got.size(), 4);
    if (got.size() == 4) begin
      check("stat_k", got[0], 8'h4B);
      check("stat_b0", got[1], 8'h1C);
      check("stat_b1", got[2], 8'h12);
      check("stat_b2", got[3], 8'h34);
    end

    // Argument timeout, then '1' accepted
    got.delete();
    send(8'h57);
    repeat (TIMEOUT + 3) step();
    check("tmo_count", got.size(), 1);
    if (got.size() > 0) check("tmo_byte", got[0], 8'h4E);
    send(8'h31); wait_idle();
    check("tmo_width1", traceWidth, 1);

    // Argument in the last permitted cycle is still taken
    got.delete();
    send(8'h57);
    repeat (TIMEOUT - 1) step();
    send(8'h02); wait_idle();
    check("late_arg_width", traceWidth, 2);
    if (got.size() > 0) check("late_arg_byte", got[got.size() - 1], 8'h4B);

    // One cycle too late: timeout 'N', then 0x02 is an unknown command
    got.delete();
    send(8'h57);
    repeat (TIMEOUT) step();
    send(8'h02); wait_idle();
    check("too_late_count", got.size(), 2);
    if (got.size() == 2) check("too_late_b1", got[1], 8'h4E);
    check("too_late_width", traceWidth, 2);

    // 'X' then rxValid held through RESP; back-to-back '1' afterwards
    got.delete(); txReady = 1'b0;
    rxValid = 1'b1; rxByte = 8'h58;
    step();
    rxByte = 8'h31;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("resp_rxReady", rxReady, 0);
      check("resp_width", traceWidth, 2);
      step();
    end
    txReady = 1'b1;
    step();
    step();
    rxValid = 1'b0;
    @(negedge clk);
    check("b2b_width", traceWidth, 1);
    check("b2b_txByte", txByte, 8'h4B);
    wait_idle();
    check("x_count", got.size(), 2);
    if (got.size() == 2) check("x_byte", got[0], 8'h4E);

    // Reset in STAT1
    send(8'h45); wait_idle(); send(8'h32); wait_idle();
    txReady = 1'b0; ovfCount = 16'h5678;
    send(8'h53);
    txReady = 1'b1;
    step();
    txReady = 1'b0;
    @(negedge clk);
    check("stat1_byte", txByte, 8'h56);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_txValid", txValid, 0);
    check("mid_rst_width", traceWidth, 4);
    check("mid_rst_en", traceEn, 0);
    check("mid_rst_rxReady", rxReady, 1);
    step();
    got.delete(); txReady = 1'b1;
    send(8'h44); wait_idle();
    check("after_rst_count", got.size(), 1);
    if (got.size() > 0) check("after_rst_byte", got[0], 8'h4B);

    // Randomized traffic
    tx_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      int prob;
      prob     = ((i / 500) % 2 == 1) ? 3 : 40;
      rxValid  = ($urandom_range(0, 99) < prob);
      rxByte   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pick[$urandom_range(0, 9)];
      ovfCount = 16'($urandom);
      syncLost = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 999) == 0);
      step();
    end
    rxValid = 1'b0; rst = 1'b0; tx_mode = 0; txReady = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
